// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared definitions for the instruction fetch stage.
// Contents:
//   - the fetch FSM state encoding
//   - the NOP word loaded into the instruction register by reset
//   - the default reset PC
//   - the opcode constants shared with the main controller
//   - a helper that flags a word-misaligned target address
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    ISSUE = 2'b01,
    FAULT = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // A target is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc          current PC
//   i_pc_src      taken branch from the controller
//   i_jump        JAL decoded by the controller
//   i_target_addr branch/jump target from the datapath adder
//   o_pc_plus4    i_pc + 4, modulo 2^XLEN (also the JAL link value)
//   o_next_pc     word-aligned target on a redirect, otherwise i_pc + 4
//   o_misaligned  a redirect is requested to a target with nonzero low bits
module pc_next_sel
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_target_addr,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic            w_redirect;
  logic [XLEN-1:0] w_target_aligned;

  // Addition wraps naturally at the top of the address space.
  assign o_pc_plus4       = i_pc + XLEN'(32'd4);
  assign w_redirect       = i_pc_src | i_jump;
  assign w_target_aligned = {i_target_addr[XLEN-1:2], 2'b00};
  assign o_misaligned     = w_redirect & is_misaligned(i_target_addr[1:0]);

  // Redirect mux: a branch or jump overrides sequential fetch.
  always_comb begin
    o_next_pc = o_pc_plus4;
    if (w_redirect) begin
      o_next_pc = w_target_aligned;
    end else begin
      o_next_pc = o_pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage ahead of the main controller.
// Holds the PC, fetches one word at a time over a req/ack handshake, latches
// it and presents its fields to the controller and register file.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   stall                    hold the current instruction in ISSUE
//   pc_src, jump, target_addr redirect request, sampled in ISSUE without stall
//   imem_req/addr/ack/rdata  instruction memory handshake
//   instr_valid, instr, pc, pc_plus4  latched instruction and its address
//   op, funct3, funct7, funct77, rd, rs1, rs2  field slices of instr
//   fetch_fault              only when IFU_MISALIGN_TRAP_EN is defined
// Build option IFU_MISALIGN_TRAP_EN: a redirect to a misaligned target parks
// the unit in FAULT (pc = raw target) until reset. Without it the two low
// target bits are simply dropped.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_src,
  input  logic            jump,
  input  logic [XLEN-1:0] target_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [6:0]      funct77,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic            fetch_fault,
`endif
  output logic [4:0]      rs2
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_instr_valid;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .i_pc          (r_pc),
    .i_pc_src      (pc_src),
    .i_jump        (jump),
    .i_target_addr (target_addr),
    .o_pc_plus4    (pc_plus4),
    .o_next_pc     (w_next_pc),
    .o_misaligned  (w_misaligned)
  );

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_fetch_fault;
  assign fetch_fault = r_fetch_fault;
`else
  logic w_unused_misaligned;
  assign w_unused_misaligned = w_misaligned;
`endif

  // Request is a decode of the registered state, forced low while rst is held
  // so the memory never sees a request during reset.
  assign imem_req    = (r_state == FETCH) & ~rst;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign op          = r_instr[6:0];
  assign rd          = r_instr[11:7];
  assign funct3      = r_instr[14:12];
  assign rs1         = r_instr[19:15];
  assign rs2         = r_instr[24:20];
  assign funct77     = r_instr[31:25];
  assign funct7      = r_instr[30];

  // Fetch FSM with the PC, instruction register and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      r_fetch_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH: begin
          // Address stays on r_pc until the memory acknowledges.
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Acks arriving here are stale and deliberately ignored.
          if (!stall) begin
            r_instr_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              r_state       <= FAULT;
              r_pc          <= target_addr;
              r_fetch_fault <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_pc    <= w_next_pc;
            end
`else
            r_state <= FETCH;
            r_pc    <= w_next_pc;
`endif
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        FAULT: begin
          // Terminal until reset.
          r_instr_valid <= 1'b0;
          r_fetch_fault <= 1'b1;
        end
`endif
        default: begin
          r_state       <= FETCH;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, pc_src, jump, imem_ack;
  logic [31:0] target_addr, imem_rdata;
  logic        imem_req, instr_valid, funct7;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [6:0]  op, funct77;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_fault;
  localparam logic [31:0] J_TGT = 32'h0000_0044;
  localparam logic [31:0] J_NXT = 32'h0000_0044;
`else
  localparam logic [31:0] J_TGT = 32'h0000_0042;
  localparam logic [31:0] J_NXT = 32'h0000_0040;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .jump(jump),
    .target_addr(target_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .op(op), .funct3(funct3),
    .funct7(funct7), .funct77(funct77), .rd(rd), .rs1(rs1),
`ifdef IFU_MISALIGN_TRAP_EN
    .fetch_fault(fetch_fault),
`endif
    .rs2(rs2)
  );

  typedef struct {
    logic [31:0] word;
    int          stall_n;
    logic        psrc;
    logic        jmp;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f77;
    logic [31:0] nxt;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; pc_src = 1'b0; jump = 1'b0; target_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Expected fields come straight from the instruction format.
  task automatic chk_fields(input logic [31:0] w);
    chk("op", 32'(op), 32'(w[6:0]));
    chk("rd", 32'(rd), 32'(w[11:7]));
    chk("funct3", 32'(funct3), 32'(w[14:12]));
    chk("rs1", 32'(rs1), 32'(w[19:15]));
    chk("rs2", 32'(rs2), 32'(w[24:20]));
    chk("funct77", 32'(funct77), 32'(w[31:25]));
    chk("funct7", 32'(funct7), 32'(w[30]));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc", pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
  endtask

  // Zero-wait fetch of w, then release with the given redirect.
  task automatic one_instr(input logic [31:0] w, input logic ps, input logic [31:0] t);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0;
    stall = 1'b0; pc_src = ps; target_addr = t;
    tick();
    pc_src = 1'b0; target_addr = 32'h0;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  logic [31:0] exp_addr, w;
  logic        exp_fetch;
  int          wait_left;

  initial begin
    rst = 1'b1;
    idle_inputs();

    vt[0] = '{32'h0050_0093, 0, 1'b0, 1'b0, 32'h0,  32'h00, OP_ITYPE,  5'd1,  5'd0, 5'd5,  3'd0, 7'h00, 32'h04};
    vt[1] = '{32'h4020_8033, 0, 1'b1, 1'b0, 32'h10, 32'h04, OP_RTYPE,  5'd0,  5'd1, 5'd2,  3'd0, 7'h20, 32'h10};
    vt[2] = '{32'h00C0_006F, 0, 1'b1, 1'b0, 32'h40, 32'h10, OP_JAL,    5'd0,  5'd0, 5'd12, 3'd0, 7'h00, 32'h40};
    vt[3] = '{32'h0000_A103, 0, 1'b0, 1'b1, J_TGT,  32'h40, OP_LOAD,   5'd2,  5'd1, 5'd0,  3'd2, 7'h00, J_NXT};
    vt[4] = '{32'h0011_2223, 0, 1'b1, 1'b0, 32'h20, J_NXT,  OP_STORE,  5'd4,  5'd2, 5'd1,  3'd2, 7'h00, 32'h20};
    vt[5] = '{32'hFE00_0EE3, 4, 1'b0, 1'b0, 32'h0,  32'h20, OP_BRANCH, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'h24};
    vt[6] = '{32'h1234_50B7, 2, 1'b1, 1'b0, 32'h30, 32'h24, OP_LUI,    5'd1,  5'd8, 5'd3,  3'd5, 7'h09, 32'h30};

    do_reset();

    // Table: zero-wait fetch, field decode, stall hold, redirect selection.
    for (int i = 0; i < 7; i++) begin
      chk("tbl_req", 32'(imem_req), 32'd1);
      chk("tbl_addr", imem_addr, vt[i].pc);
      chk("tbl_fetch_valid", 32'(instr_valid), 32'd0);
      imem_ack = 1'b1; imem_rdata = vt[i].word;
      tick();
      imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      chk("tbl_valid", 32'(instr_valid), 32'd1);
      chk("tbl_instr", instr, vt[i].word);
      chk("tbl_pc", pc, vt[i].pc);
      chk("tbl_pc4", pc_plus4, vt[i].pc + 32'd4);
      chk("tbl_issue_req", 32'(imem_req), 32'd0);
      chk("tbl_op", 32'(op), 32'(vt[i].op));
      chk("tbl_rd", 32'(rd), 32'(vt[i].rd));
      chk("tbl_rs1", 32'(rs1), 32'(vt[i].rs1));
      chk("tbl_rs2", 32'(rs2), 32'(vt[i].rs2));
      chk("tbl_f3", 32'(funct3), 32'(vt[i].f3));
      chk("tbl_f77", 32'(funct77), 32'(vt[i].f77));
      chk("tbl_f7", 32'(funct7), 32'(vt[i].f77[5]));
      for (int k = 0; k < vt[i].stall_n; k++) begin
        stall = 1'b1; pc_src = 1'b1; target_addr = 32'h80;
        imem_ack = (k == 0); imem_rdata = 32'h0BAD_0BAD;
        tick();
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_pc", pc, vt[i].pc);
        chk("stall_instr", instr, vt[i].word);
      end
      stall = 1'b0; imem_ack = 1'b0;
      pc_src = vt[i].psrc; jump = vt[i].jmp; target_addr = vt[i].tgt;
      tick();
      pc_src = 1'b0; jump = 1'b0; target_addr = 32'h0;
      chk("rel_valid", 32'(instr_valid), 32'd0);
      chk("rel_req", 32'(imem_req), 32'd1);
      chk("rel_addr", imem_addr, vt[i].nxt);
    end

    // Reset in FETCH with an ack in the same cycle.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    chk("rstack_instr", instr, NOP_INSTR);
    chk("rstack_valid", 32'(instr_valid), 32'd0);
    chk("rstack_pc", pc, 32'h0);
    chk("rstack_req", 32'(imem_req), 32'd0);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rstack_req_after", 32'(imem_req), 32'd1);
    chk("rstack_addr_after", imem_addr, 32'h0);

    // Delayed ack at pc=8, plus a stale ack while in ISSUE.
    one_instr(NOP_INSTR, 1'b0, 32'h0);
    one_instr(NOP_INSTR, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h8);
      tick();
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0030_0113;
    tick();
    chk("late_valid", 32'(instr_valid), 32'd1);
    chk("late_instr", instr, 32'h0030_0113);
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("stale_ack_instr", instr, 32'h0030_0113);
    stall = 1'b0; imem_ack = 1'b0;
    tick();
    chk("late_next_addr", imem_addr, 32'hC);

    // PC wraparound at the top of the address space.
    one_instr(NOP_INSTR, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = NOP_INSTR;
    tick();
    imem_ack = 1'b0;
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick();
    chk("wrap_next", imem_addr, 32'h0);

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned redirect parks the unit in FAULT until reset.
    one_instr(NOP_INSTR, 1'b1, 32'h46);
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1;
      chk("fault_flag", 32'(fetch_fault), 32'd1);
      chk("fault_pc", pc, 32'h46);
      chk("fault_req", 32'(imem_req), 32'd0);
      chk("fault_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    do_reset();
    chk("fault_cleared", 32'(fetch_fault), 32'd0);
`endif

    // Randomized run against a transaction-level reference model.
    do_reset();
    exp_fetch = 1'b1;
    exp_addr  = 32'h0;
    wait_left = $urandom_range(0, 3);
    for (int c = 0; c < 1500; c++) begin
      w = word_at(exp_addr);
      if (exp_fetch) begin
        chk("rnd_req", 32'(imem_req), 32'd1);
        chk("rnd_addr", imem_addr, exp_addr);
        chk("rnd_fetch_valid", 32'(instr_valid), 32'd0);
        imem_ack   = (wait_left == 0);
        imem_rdata = imem_ack ? w : $urandom;
        stall      = 1'($urandom_range(0, 1));
        pc_src     = 1'($urandom_range(0, 1));
        jump       = 1'($urandom_range(0, 1));
        target_addr = $urandom;
      end else begin
        chk("rnd_issue_req", 32'(imem_req), 32'd0);
        chk("rnd_valid", 32'(instr_valid), 32'd1);
        chk("rnd_pc", pc, exp_addr);
        chk("rnd_pc4", pc_plus4, exp_addr + 32'd4);
        chk("rnd_instr", instr, w);
        chk_fields(w);
        stall      = ($urandom_range(0, 3) == 0);
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        pc_src     = ($urandom_range(0, 3) == 0);
        jump       = ($urandom_range(0, 5) == 0);
        target_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
        target_addr = target_addr & 32'hFFFF_FFFC;
`endif
      end
      tick();
      if (exp_fetch) begin
        if (imem_ack) exp_fetch = 1'b0;
        else wait_left = wait_left - 1;
      end else if (!stall) begin
        exp_addr  = (pc_src | jump) ? (target_addr & 32'hFFFF_FFFC) : exp_addr + 32'd4;
        exp_fetch = 1'b1;
        wait_left = $urandom_range(0, 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
